// File: rtl/game_sequencer_if.sv
// Purpose: bundles the player controls, gameplay events and game-flow outputs of game_sequencer.
// Latency: none; wires only.
// Backpressure: none; every event is a pulse or a level and is never stalled.
// Ports:
//   master = game_sequencer side. It receives the buttons/events and drives state/enables/counters.
//   slave  = board/datapath side. It drives the buttons/events and receives the game-flow outputs.
interface game_sequencer_if #(
    parameter int SCORE_W = 14
);
    // player controls and gameplay events (into the sequencer)
    logic               start;
    logic               play;
    logic               frame_tick;
    logic               alien_killed;
    logic               player_hit;
    logic               wave_clear;
    logic               aliens_landed;

    // game-flow outputs (from the sequencer)
    logic [2:0]         state;
    logic               run_en;
    logic               game_init;
    logic               wave_init;
    logic [1:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [3:0]         wave;

    modport master (
        input  start, play, frame_tick, alien_killed, player_hit, wave_clear, aliens_landed,
        output state, run_en, game_init, wave_init, lives, score, wave
    );

    modport slave (
        output start, play, frame_tick, alien_killed, player_hit, wave_clear, aliens_landed,
        input  state, run_en, game_init, wave_init, lives, score, wave
    );
endinterface

// File: rtl/game_sequencer.sv
// Purpose: Space Invaders game-flow FSM. Owns lives/score/wave and gates the datapath with run_en and the init pulses.
// Latency: every decision registers on the next clk edge; outputs are Moore-decoded from the registered state.
// Backpressure: none; events are sampled every cycle, and delays are counted in frame_tick pulses.
// Ports: clk, reset (sync, active-high); bus (game_sequencer_if.master) carries all buttons, events and outputs.
module game_sequencer #(
    parameter int LIVES        = 3,
    parameter int DEATH_FRAMES = 60,
    parameter int WAVE_FRAMES  = 90,
    parameter int OVER_FRAMES  = 180,
    parameter int KILL_POINTS  = 10,
    parameter int SCORE_W      = 14
) (
    input  logic             clk,
    input  logic             reset,
    game_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_ATTRACT   = 3'd0,
        ST_INIT      = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_DYING     = 3'd4,
        ST_WAVE_DONE = 3'd5,
        ST_WAVE_INIT = 3'd6,
        ST_GAME_OVER = 3'd7
    } state_t;

    // The timer exits on the tick that arrives while it holds N-1.
    localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] WAVE_LAST  = 8'(WAVE_FRAMES - 1);
    localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);

    localparam logic [SCORE_W:0]   KILL_ADD  = (SCORE_W + 1)'(KILL_POINTS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t             state_q, state_d;
    logic               start_q;
    logic [7:0]         timer_q, timer_d;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         wave_q, wave_d;

    logic               start_rise;
    logic               timer_inc;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_kill;

    assign start_rise = bus.start & ~start_q;

    // One extra bit holds the carry, so saturation is a single-bit test.
    assign score_sum  = {1'b0, score_q} + KILL_ADD;
    assign score_kill = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ATTRACT;
            start_q <= 1'b0;
            timer_q <= '0;
            lives_q <= '0;
            score_q <= '0;
            wave_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
            timer_q <= timer_d;
            lives_q <= lives_d;
            score_q <= score_d;
            wave_q  <= wave_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        wave_d    = wave_q;
        timer_inc = 1'b0;

        case (state_q)
            ST_ATTRACT: begin
                // Edge-triggered, so a start button held through GAME_OVER cannot relaunch.
                if (start_rise) state_d = ST_INIT;
            end
            ST_INIT: begin
                score_d = '0;
                lives_d = 2'(LIVES);
                wave_d  = 4'd1;
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // A kill is credited even when a higher-priority event also leaves PLAY this cycle.
                if (bus.alien_killed) score_d = score_kill;
                if (bus.aliens_landed) begin
                    lives_d = 2'd0;
                    state_d = ST_GAME_OVER;
                end else if (bus.player_hit) begin
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = ST_GAME_OVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = ST_DYING;
                    end
                end else if (bus.wave_clear) begin
                    state_d = ST_WAVE_DONE;
                end else if (!bus.play) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (bus.play) state_d = ST_PLAY;
            end
            ST_DYING: begin
                if (bus.frame_tick) begin
                    timer_inc = 1'b1;
                    if (timer_q == DEATH_LAST) state_d = ST_PLAY;
                end
            end
            ST_WAVE_DONE: begin
                if (bus.frame_tick) begin
                    timer_inc = 1'b1;
                    if (timer_q == WAVE_LAST) state_d = ST_WAVE_INIT;
                end
            end
            ST_WAVE_INIT: begin
                if (wave_q != 4'd15) wave_d = wave_q + 4'd1;
                state_d = ST_PLAY;
            end
            ST_GAME_OVER: begin
                if (bus.frame_tick) begin
                    timer_inc = 1'b1;
                    if (timer_q == OVER_LAST) state_d = ST_ATTRACT;
                end
            end
            default: state_d = ST_ATTRACT;
        endcase
    end

    // Every state change clears the timer. A tick on the cycle that enters a state
    // is seen by the old state, so it never counts toward the new state's delay.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) timer_d = '0;
        else if (timer_inc)     timer_d = timer_q + 8'd1;
    end

    assign bus.state     = state_q;
    assign bus.run_en    = (state_q == ST_PLAY);
    assign bus.game_init = (state_q == ST_INIT);
    assign bus.wave_init = (state_q == ST_INIT) || (state_q == ST_WAVE_INIT);
    assign bus.lives     = lives_q;
    assign bus.score     = score_q;
    assign bus.wave      = wave_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Purpose: directed self-checking bench for game_sequencer with short frame delays and a 5-bit score.
// Latency: inputs change 1 ns after a rising edge; outputs are checked 1 ns after the next edge.
// Backpressure: not applicable; the bench is a fixed directed sequence with no open-ended waits.
module tb_game_sequencer;

    localparam int SCORE_W = 5;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    game_sequencer_if #(.SCORE_W(SCORE_W)) bus_if ();

    game_sequencer #(
        .LIVES        (3),
        .DEATH_FRAMES (2),
        .WAVE_FRAMES  (2),
        .OVER_FRAMES  (3),
        .KILL_POINTS  (10),
        .SCORE_W      (SCORE_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic kill_pulse();
        bus_if.alien_killed = 1'b1;
        step();
        bus_if.alien_killed = 1'b0;
        step();
    endtask

    task automatic tick_pulse();
        bus_if.frame_tick = 1'b1;
        step();
        bus_if.frame_tick = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".state"},     32'(bus_if.state),     32'd0);
        chk({tag, ".run_en"},    32'(bus_if.run_en),    32'd0);
        chk({tag, ".game_init"}, 32'(bus_if.game_init), 32'd0);
        chk({tag, ".wave_init"}, 32'(bus_if.wave_init), 32'd0);
        chk({tag, ".lives"},     32'(bus_if.lives),     32'd0);
        chk({tag, ".score"},     32'(bus_if.score),     32'd0);
        chk({tag, ".wave"},      32'(bus_if.wave),      32'd0);
    endtask

    // Rising start from ATTRACT: one INIT cycle, then PLAY with a fresh game loaded.
    task automatic new_game(input string tag);
        bus_if.start = 1'b0;
        step();
        bus_if.start = 1'b1;
        step();
        chk({tag, ".init"}, 32'(bus_if.state), 32'd1);
        bus_if.start = 1'b0;
        step();
        chk({tag, ".play"},  32'(bus_if.state), 32'd2);
        chk({tag, ".lives"}, 32'(bus_if.lives), 32'd3);
        chk({tag, ".score"}, 32'(bus_if.score), 32'd0);
        chk({tag, ".wave"},  32'(bus_if.wave),  32'd1);
    endtask

    initial begin
        int init_cnt;
        int ginit_cnt;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus_if.start         = 1'b0;
        bus_if.play          = 1'b1;
        bus_if.frame_tick    = 1'b0;
        bus_if.alien_killed  = 1'b0;
        bus_if.player_hit    = 1'b0;
        bus_if.wave_clear    = 1'b0;
        bus_if.aliens_landed = 1'b0;
        step();
        step();
        check_reset_values("rst");
        reset = 1'b0;
        step();
        chk("attract_idle", 32'(bus_if.state), 32'd0);

        // Start held for 10 cycles: exactly one INIT / game_init cycle.
        bus_if.start = 1'b1;
        init_cnt  = 0;
        ginit_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus_if.state == 3'd1) init_cnt++;
            if (bus_if.game_init)     ginit_cnt++;
        end
        chk("start.init_cycles",  32'(init_cnt),          32'd1);
        chk("start.game_init",    32'(ginit_cnt),         32'd1);
        chk("start.state",        32'(bus_if.state),      32'd2);
        chk("start.lives",        32'(bus_if.lives),      32'd3);
        chk("start.score",        32'(bus_if.score),      32'd0);
        chk("start.wave",         32'(bus_if.wave),       32'd1);
        chk("start.run_en",       32'(bus_if.run_en),     32'd1);
        bus_if.start = 1'b0;

        // Three kills: 30.
        for (int i = 0; i < 3; i++) kill_pulse();
        chk("score.3kills", 32'(bus_if.score), 32'd30);

        // Pause: kills are ignored, and play=1 resumes.
        bus_if.play = 1'b0;
        step();
        chk("pause.state",  32'(bus_if.state),  32'd3);
        chk("pause.run_en", 32'(bus_if.run_en), 32'd0);
        kill_pulse();
        kill_pulse();
        chk("pause.score", 32'(bus_if.score), 32'd30);
        chk("pause.hold",  32'(bus_if.state), 32'd3);
        bus_if.play = 1'b1;
        step();
        chk("resume.state", 32'(bus_if.state), 32'd2);

        // 30 + 10 = 40 is above 2^5-1, so the score saturates at 31.
        kill_pulse();
        chk("score.sat", 32'(bus_if.score), 32'd31);

        // Hit with 3 lives. A tick on the entry edge must not count.
        bus_if.player_hit = 1'b1;
        bus_if.frame_tick = 1'b1;
        step();
        bus_if.player_hit = 1'b0;
        bus_if.frame_tick = 1'b0;
        chk("hit.state",  32'(bus_if.state),  32'd4);
        chk("hit.lives",  32'(bus_if.lives),  32'd2);
        chk("hit.run_en", 32'(bus_if.run_en), 32'd0);
        step();
        tick_pulse();
        chk("dying.tick1", 32'(bus_if.state), 32'd4);
        step();
        tick_pulse();
        chk("dying.tick2", 32'(bus_if.state), 32'd2);

        // Wave clear: two ticks, one WAVE_INIT cycle, then PLAY on wave 2.
        bus_if.wave_clear = 1'b1;
        step();
        bus_if.wave_clear = 1'b0;
        chk("wclr.state", 32'(bus_if.state), 32'd5);
        tick_pulse();
        chk("wclr.tick1", 32'(bus_if.state), 32'd5);
        tick_pulse();
        chk("winit.state",     32'(bus_if.state),     32'd6);
        chk("winit.wave_init", 32'(bus_if.wave_init), 32'd1);
        chk("winit.game_init", 32'(bus_if.game_init), 32'd0);
        step();
        chk("winit.play", 32'(bus_if.state),     32'd2);
        chk("winit.wave", 32'(bus_if.wave),      32'd2);
        chk("winit.end",  32'(bus_if.wave_init), 32'd0);

        // Second hit (3 -> 2 -> 1 lives), back to PLAY.
        bus_if.player_hit = 1'b1;
        step();
        bus_if.player_hit = 1'b0;
        chk("hit2.lives", 32'(bus_if.lives), 32'd1);
        tick_pulse();
        tick_pulse();
        chk("hit2.back", 32'(bus_if.state), 32'd2);

        // Last life lost -> GAME_OVER, with start held high from here on.
        bus_if.start      = 1'b1;
        bus_if.player_hit = 1'b1;
        step();
        bus_if.player_hit = 1'b0;
        chk("last.state", 32'(bus_if.state), 32'd7);
        chk("last.lives", 32'(bus_if.lives), 32'd0);
        tick_pulse();
        tick_pulse();
        chk("over.tick2", 32'(bus_if.state), 32'd7);
        tick_pulse();
        chk("over.tick3", 32'(bus_if.state), 32'd0);
        step();
        step();
        step();
        chk("over.no_restart", 32'(bus_if.state), 32'd0);
        chk("over.score_hold", 32'(bus_if.score), 32'd31);

        // New game; aliens land while a kill is credited on the same cycle.
        new_game("g2");
        bus_if.aliens_landed = 1'b1;
        bus_if.alien_killed  = 1'b1;
        step();
        bus_if.aliens_landed = 1'b0;
        bus_if.alien_killed  = 1'b0;
        chk("land.state", 32'(bus_if.state), 32'd7);
        chk("land.lives", 32'(bus_if.lives), 32'd0);
        chk("land.score", 32'(bus_if.score), 32'd10);
        bus_if.start = 1'b1;
        tick_pulse();
        tick_pulse();
        tick_pulse();
        chk("land.attract", 32'(bus_if.state), 32'd0);
        step();
        chk("land.no_restart", 32'(bus_if.state), 32'd0);

        // Reset in the middle of DYING.
        new_game("g3");
        bus_if.player_hit = 1'b1;
        step();
        bus_if.player_hit = 1'b0;
        chk("g3.dying", 32'(bus_if.state), 32'd4);
        tick_pulse();
        reset = 1'b1;
        bus_if.frame_tick = 1'b1;
        step();
        bus_if.frame_tick = 1'b0;
        check_reset_values("midrst");
        reset = 1'b0;
        step();
        chk("midrst.idle", 32'(bus_if.state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
